// File: rtl/trigger_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module : trigger_sequencer
// Arms capture, turns trigger edges into bounded capture windows with a
// holdoff, and forwards host settings writes. Define ADAPTIVE_THRES_EN to
// inject noise-floor derived threshold writes.
// Rev    : 1.0
//============================================================================
module trigger_sequencer #(
    parameter logic [7:0]  THRES_ADDR = 8'd3,
    parameter int          MIN_LEN    = 16,
    parameter int          AVG_LOG2   = 6,
    parameter int          THR_SHIFT  = 2,
    parameter logic [15:0] THR_OFFSET = 16'd32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_in_strobe,
    input  logic        trigger,
    input  logic        arm,
    input  logic        abort,
    input  logic [15:0] cfg_max_len,
    input  logic [15:0] cfg_holdoff,
    input  logic        cfg_continuous,
    input  logic        host_set_stb,
    input  logic [7:0]  host_set_addr,
    input  logic [31:0] host_set_data,
    output logic        set_stb,
    output logic [7:0]  set_addr,
    output logic [31:0] set_data,
    output logic        capture_en,
    output logic        capture_start,
    output logic        capture_done,
    output logic [15:0] pkt_count,
    output logic [1:0]  state_out,
    output logic        thr_valid
);

    localparam logic [15:0] c_min_len = 16'(MIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_CAPTURE  = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_trigger_d;
    logic [15:0] r_count;

    wire         w_trig_rise   = trigger & ~r_trigger_d;
    wire  [15:0] w_count_inc   = r_count + 16'd1;
    // A 16-bit count wraps to 0 on the 65536th strobe, so cfg_max_len == 0 caps at 65536.
    wire         w_cap_len_hit = sample_in_strobe && (w_count_inc == cfg_max_len);
    wire         w_cap_fall    = !trigger && (r_count >= c_min_len);
    wire         w_hold_done   = (r_count == cfg_holdoff);

    assign state_out = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_trigger_d <= 1'b0;
        end else begin
            r_trigger_d <= trigger;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_count       <= 16'd0;
            capture_en    <= 1'b0;
            capture_start <= 1'b0;
            capture_done  <= 1'b0;
            pkt_count     <= 16'd0;
        end else begin
            capture_start <= 1'b0;
            capture_done  <= 1'b0;
            if (enable) begin
                if (abort) begin
                    if (r_state == S_CAPTURE) capture_done <= 1'b1;
                    capture_en <= 1'b0;
                    r_count    <= 16'd0;
                    r_state    <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (arm) r_state <= S_ARMED;
                        end
                        S_ARMED: begin
                            if (w_trig_rise) begin
                                r_state       <= S_CAPTURE;
                                capture_start <= 1'b1;
                                capture_en    <= 1'b1;
                                r_count       <= 16'd0;
                            end
                        end
                        S_CAPTURE: begin
                            if (w_cap_fall || w_cap_len_hit) begin
                                r_state      <= S_COOLDOWN;
                                capture_done <= 1'b1;
                                capture_en   <= 1'b0;
                                r_count      <= 16'd0;
                                if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
                            end else if (sample_in_strobe) begin
                                r_count <= w_count_inc;
                            end
                        end
                        S_COOLDOWN: begin
                            if (w_hold_done) begin
                                r_state <= cfg_continuous ? S_ARMED : S_IDLE;
                                r_count <= 16'd0;
                            end else if (sample_in_strobe) begin
                                r_count <= w_count_inc;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef ADAPTIVE_THRES_EN
    localparam int c_acc_w = 17 + AVG_LOG2;

    logic [c_acc_w-1:0]  r_acc;
    logic [AVG_LOG2-1:0] r_win;
    logic                r_pend;
    logic [15:0]         r_pend_thr;

    // |I| needs 17 bits so that -32768 maps to +32768.
    wire  [16:0]          w_abs_i      = sample_in[31] ? (17'd0 - {1'b1, sample_in[31:16]})
                                                       : {1'b0, sample_in[31:16]};
    wire  [c_acc_w-1:0]   w_acc_next   = r_acc + {{AVG_LOG2{1'b0}}, w_abs_i};
    wire  [16:0]          w_mean       = w_acc_next[c_acc_w-1:AVG_LOG2];
    wire  [17+THR_SHIFT:0] w_thr_wide  = ({{(THR_SHIFT+1){1'b0}}, w_mean} << THR_SHIFT)
                                       + {{(THR_SHIFT+2){1'b0}}, THR_OFFSET};
    wire  [15:0]          w_thr        = (|w_thr_wide[17+THR_SHIFT:16]) ? 16'hFFFF : w_thr_wide[15:0];
    wire                  w_acc_active = (r_state == S_ARMED) && !trigger;
    wire                  w_window_end = enable && w_acc_active && sample_in_strobe && (r_win == '1);
    wire                  w_ctrl_issue = r_pend && !host_set_stb;
    wire                  w_unused_q   = ^sample_in[15:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_win      <= '0;
            r_pend     <= 1'b0;
            r_pend_thr <= 16'd0;
            thr_valid  <= 1'b0;
        end else begin
            thr_valid <= w_ctrl_issue;
            if (!w_acc_active) begin
                r_acc <= '0;
                r_win <= '0;
            end else if (enable && sample_in_strobe) begin
                r_acc <= (r_win == '1) ? '0 : w_acc_next;
                r_win <= r_win + AVG_LOG2'(1);
            end
            // A fresh threshold replaces whatever was pending; a host write to the threshold register cancels it.
            if (w_window_end) begin
                r_pend     <= 1'b1;
                r_pend_thr <= w_thr;
            end else if (r_pend && (!host_set_stb || (host_set_addr == THRES_ADDR))) begin
                r_pend <= 1'b0;
            end
        end
    end
`else
    wire w_ctrl_issue = 1'b0;
    wire [15:0] r_pend_thr = 16'd0;
    wire w_unused_in = ^{sample_in, THRES_ADDR};
    assign thr_valid = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            set_stb  <= 1'b0;
            set_addr <= 8'd0;
            set_data <= 32'd0;
        end else begin
            set_stb <= 1'b0;
            if (host_set_stb) begin
                set_stb  <= 1'b1;
                set_addr <= host_set_addr;
                set_data <= host_set_data;
            end else if (w_ctrl_issue) begin
                set_stb  <= 1'b1;
                set_addr <= THRES_ADDR;
                set_data <= {16'd0, r_pend_thr};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Controller that sequences the packet power trigger and the downstream CSI capture path.
- Arms capture, turns trigger edges into bounded capture windows, and enforces a post-packet holdoff.
- Sits between the host settings bus and the power trigger, forwarding settings writes to it.
- Optionally injects threshold writes derived from a measured noise floor.

Parameters:
- THRES_ADDR, 8'd3: settings address of the power-trigger threshold register.
- MIN_LEN, 16: minimum strobed samples in a capture before a trigger fall may end it.
- AVG_LOG2, 6: log2 of the noise-floor averaging window, 2^AVG_LOG2 samples (ADAPTIVE_THRES_EN only).
- THR_SHIFT, 2: left shift applied to the mean noise magnitude.
- THR_OFFSET, 16'd32: offset added after the shift.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  low freezes the FSM and counters; outputs hold
- sample_in  in  32  I in [31:16], Q in [15:0]
- sample_in_strobe  in  1  sample valid
- trigger  in  1  level from the power trigger
- arm  in  1  pulse: IDLE->ARMED
- abort  in  1  pulse: any state->IDLE
- cfg_max_len  in  16  capture length cap in samples; 0 means 65536
- cfg_holdoff  in  16  cooldown length in samples
- cfg_continuous  in  1  1: COOLDOWN returns to ARMED; 0: returns to IDLE
- host_set_stb  in  1  host settings strobe
- host_set_addr  in  8  host settings address
- host_set_data  in  32  host settings data
- set_stb  out  1  settings strobe to the power trigger
- set_addr  out  8  settings address to the power trigger
- set_data  out  32  settings data to the power trigger
- capture_en  out  1  high during CAPTURE
- capture_start  out  1  one-cycle pulse on CAPTURE entry
- capture_done  out  1  one-cycle pulse on CAPTURE exit
- pkt_count  out  16  completed captures, saturating
- state_out  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 COOLDOWN
- thr_valid  out  1  one-cycle pulse when an adaptive threshold write is issued

Behaviour:
- Reset: all outputs, counters and the trigger-edge register are 0; state is IDLE.
- Trigger edge: trig_rise = trigger & ~trigger_d, sampled every clock. trigger_d updates every clock, including while enable is low.
- IDLE: on arm, go to ARMED. arm is ignored in every other state.
- ARMED: on trig_rise, go to CAPTURE. capture_start pulses the same cycle the state register updates. capture_en is high from that cycle onward. The sample counter clears.
- CAPTURE: the counter increments on each sample_in_strobe. Exit to COOLDOWN when either:
  - trigger == 0 and count >= MIN_LEN, or
  - count reaches cfg_max_len (16-bit count wraps, so 0 means 65536).
  - If both hold in the same cycle, exit once.
  - On exit: capture_done pulses, capture_en drops, pkt_count increments (saturates at 16'hFFFF), counter clears.
- COOLDOWN: count strobed samples. At count == cfg_holdoff, go to ARMED if cfg_continuous, else IDLE. cfg_holdoff == 0 exits on the first cycle.
- abort: priority over every transition; next state is IDLE. Aborting from CAPTURE pulses capture_done but does not increment pkt_count. abort and arm in the same cycle resolve to IDLE.
- Settings bus: host writes are registered through with 1-cycle latency, unchanged. The block also decodes nothing locally.
- Settings arbitration: the host always wins. A pending controller write issues only in a cycle where host_set_stb is 0. The pending write stays held until it issues. A host write to THRES_ADDR cancels any pending controller write.

Optional Feature:
- Macro: ADAPTIVE_THRES_EN.
- Defined:
  - In ARMED with trigger low, accumulate |I| over 2^AVG_LOG2 strobes. |-32768| = 32768, so |I| is 17 bits; the accumulator is 17+AVG_LOG2 bits.
  - At window end: thr = min(16'hFFFF, ((sum >> AVG_LOG2) << THR_SHIFT) + THR_OFFSET).
  - Post a pending write {THRES_ADDR, {16'd0, thr}}. thr_valid pulses when that write issues.
  - The accumulator clears on leaving ARMED or when trigger is high. The window restarts afterwards.
- Undefined: no accumulator, no controller writes, thr_valid tied 0, and the bus is a pure registered passthrough.

Test Plan:
- Capture on trigger: reset, arm, trigger high for 100 strobes then low, cfg_max_len=1000, cfg_holdoff=10, cfg_continuous=0.
  -> capture_start 1 cycle after the rise; capture_done when trigger falls (count 100 >= 16); pkt_count=1; IDLE after 10 strobes.
- Length cap: cfg_max_len=50, trigger held high.
  -> capture_done at strobe 50; COOLDOWN entered.
- Continuous mode with a short packet: cfg_continuous=1, two packets; the second trigger is high for only 5 strobes.
  -> after each holdoff, state_out returns to ARMED; the 5-strobe capture lasts until count reaches MIN_LEN=16 before capture_done; pkt_count=2.
- Abort mid-capture: assert abort mid-CAPTURE.
  -> capture_done pulses; pkt_count unchanged; state_out=0.
- Adaptive threshold (macro defined): constant |I|=40 for 64 strobes in ARMED.
  -> write to addr 3 with data 192 (40<<2 + 32); thr_valid pulses.
  -> If the host writes every cycle, the controller write is deferred until the first idle host cycle.
- Reset mid-CAPTURE: assert reset asynchronously.
  -> outputs 0 immediately; after release, an arm pulse is required before any capture.
